// File: rtl/vga_framebuffer.sv
// Clocked framebuffer between the pixel writer and the VGA reader: valid/ready write port,
// self-running clear engine and a 1-cycle registered RGB332 read port.
module vga_framebuffer #(
    parameter int WIDTH_X    = 120,
    parameter int WIDTH_Y    = 120,
    parameter int PIXEL_BITS = 1,
    parameter int ADDR_BITS  = $clog2(WIDTH_X * WIDTH_Y),
    parameter int COORD_BITS = 7
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iClear,
    input  logic                  iWrValid,
    output logic                  oWrReady,
    input  logic [COORD_BITS-1:0] iXm,
    input  logic [COORD_BITS-1:0] iYm,
    input  logic [PIXEL_BITS-1:0] iColor,
    input  logic                  iVideoRd,
    input  logic [COORD_BITS-1:0] iVideoMemX,
    input  logic [COORD_BITS-1:0] iVideoMemY,
    output logic [2:0]            oVGARed,
    output logic [2:0]            oVGAGreen,
    output logic [1:0]            oVGABlue,
    output logic                  oPixValid,
    output logic                  oBusy,
    output logic                  oWrErr
);

    localparam int                   DEPTH     = WIDTH_X * WIDTH_Y;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] ROW_PITCH = ADDR_BITS'(WIDTH_X);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [COORD_BITS-1:0] x,
                                                        input logic [COORD_BITS-1:0] y);
        return ADDR_BITS'(y) * ROW_PITCH + ADDR_BITS'(x);
    endfunction

    function automatic logic in_frame(input logic [COORD_BITS-1:0] x,
                                      input logic [COORD_BITS-1:0] y);
        return (int'(x) < WIDTH_X) && (int'(y) < WIDTH_Y);
    endfunction

    // Mono pixels expand to full white; 8-bit pixels are already RGB332.
    function automatic logic [7:0] to_rgb332(input logic [PIXEL_BITS-1:0] p);
        if (PIXEL_BITS == 1)
            return {8{p[0]}};
        else
            return 8'(p);
    endfunction

    logic [PIXEL_BITS-1:0] mem [0:DEPTH-1];

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  clr_cnt;
    logic                  busy, wr_ready, wr_err;
    logic                  wr_fire, wr_in_range, rd_in_range;
    logic [ADDR_BITS-1:0]  wr_addr, rd_addr;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [PIXEL_BITS-1:0] mem_wdata;
    logic [PIXEL_BITS-1:0] pix_p1;
    logic                  black_p1, vld_p1;

    assign wr_fire     = iWrValid && wr_ready;
    assign wr_in_range = in_frame(iXm, iYm);
    assign wr_addr     = pixel_addr(iXm, iYm);
    assign rd_in_range = in_frame(iVideoMemX, iVideoMemY);
    // Out-of-frame reads are forced black anyway; parking the address keeps the index legal.
    assign rd_addr     = rd_in_range ? pixel_addr(iVideoMemX, iVideoMemY) : '0;

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        wr_ready = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == LAST_ADDR) state_d = S_IDLE;
            end
            S_IDLE: begin
                wr_ready = !iClear;
                if (iClear) state_d = S_CLEAR;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Clear engine and pixel writer share the single RAM write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_fire && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = iColor;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= S_CLEAR;
            clr_cnt  <= '0;
            wr_err   <= 1'b0;
            vld_p1   <= 1'b0;
            black_p1 <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == S_CLEAR)
                clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_BITS'(1);
            if (state_q == S_IDLE && iClear)
                wr_err <= 1'b0;
            else if (wr_fire && !wr_in_range)
                wr_err <= 1'b1;
            vld_p1 <= iVideoRd;
            if (iVideoRd)
                black_p1 <= (state_q == S_CLEAR) || !rd_in_range;
        end
    end

    always_ff @(posedge iClk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // ---- read stage p1: synchronous RAM read, read-before-write ----
    always_ff @(posedge iClk) begin
        if (iVideoRd) pix_p1 <= mem[rd_addr];
    end

    assign {oVGARed, oVGAGreen, oVGABlue} = black_p1 ? 8'h00 : to_rgb332(pix_p1);
    assign oPixValid = vld_p1;
    assign oWrReady  = wr_ready;
    assign oBusy     = busy;
    assign oWrErr    = wr_err;

endmodule
